mdu_seq: RTL and testbench
==========================

# mdu_seq

Iterative multiply/divide sequencer for the RV64 execute stage. It accepts one M-extension operation per handshake, using the mul/div control fields produced by instruction decode. It runs a shared shift-add multiplier / restoring divider for a fixed number of cycles and holds the result until the writeback side takes it. RISC-V special cases (divide-by-zero, signed overflow) bypass the iteration.

## Interface
- `XLEN`, default 64: operand/result width. Only 64 is supported.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: kill the in-flight operation (pipeline redirect/trap).
- `mul_valid` in 1: request a multiply; sampled with operands when `in_ready`=1.
- `div_valid` in 1: request a divide/remainder.
- `mul_signed` in 2: [1] treat src1 as signed, [0] treat src2 as signed.
- `mul_res_lo` in 1: 1 = low XLEN bits of the product, 0 = high XLEN bits.
- `div_signed` in 2: signed divide when both bits are 1. Only values 00 and 11 are legal.
- `div_quotient` in 1: 1 = quotient, 0 = remainder.
- `inst_32` in 1: W-variant. Use operand bits [31:0]; sign-extend bit 31 of the result.
- `src1` in 64: multiplicand / dividend.
- `src2` in 64: multiplier / divisor.
- `in_ready` out 1: sequencer idle; a request is accepted this cycle.
- `busy` out 1: operation in progress (MUL or DIV state).
- `out_valid` out 1: `result` is valid.
- `out_ready` in 1: consumer takes the result.
- `result` out 64: registered result.

## Operation
- FSM states: IDLE, MUL, DIV, DONE. Reset state is IDLE.
- Reset values: `in_ready`=1, `busy`=0, `out_valid`=0, `result`=0, iteration counter=0.
- IDLE:
  - `mul_valid` & !`flush` → MUL.
  - `div_valid` & !`flush` → DIV, or directly to DONE for special cases.
  - Both valids high is illegal; mul wins.
  - Request fields and operands are captured into internal registers at acceptance.
- Operand preparation:
  - For W ops, the low 32 bits are sign-extended (signed) or zero-extended (unsigned) to 64.
  - Signed operands are converted to magnitude. A result-negate flag is recorded:
    - mul: sign1 XOR sign2.
    - quotient: sign1 XOR sign2.
    - remainder: sign1.
- MUL: unsigned shift-add, one multiplier bit per cycle into a 128-bit accumulator.
- DIV: restoring division, one quotient bit per cycle. Produces a 64-bit quotient and remainder.
- Iteration count N: 64 for 64-bit ops, 32 for W ops.
- On the final iteration edge:
  - Apply the negate flag.
  - Select lo/hi (mul) or quotient/remainder (div).
  - Apply W sign-extension.
  - Write `result` and go to DONE.
- Special cases, checked at acceptance, go IDLE→DONE with no iteration. Values are taken after the W truncate/extend.
  - Divisor = 0: quotient = all ones; remainder = dividend.
  - Signed op with dividend = most negative and divisor = −1: quotient = dividend; remainder = 0.
- DONE: `out_valid`=1 and `result` held stable until `out_ready`=1. Then → IDLE.
- `flush` in any state: next state IDLE. `out_valid` drops next cycle. `result` is not updated. A flush in the same cycle as a request blocks acceptance.
- Reset asserted mid-operation: immediate return to reset values; the operation is lost.

## Timing
- Acceptance at edge T (`in_valid`&`in_ready`, where `in_valid` = `mul_valid`|`div_valid`).
- `in_ready` low from T+1 until the cycle after the DONE handshake.
- Normal op: `busy`=1 for N cycles (T+1..T+N); `out_valid`=1 from cycle T+N+1.
  - 64-bit: first `out_valid` cycle is T+65.
  - W: T+33.
- Special case: `out_valid`=1 at T+1; `busy` stays 0.
- DONE→IDLE on the handshake edge; a new request is accepted no earlier than the following cycle.
- No combinational path from any input to `result` or `out_valid`. `in_ready` depends only on state.

## Test plan
- MUL (`mul_signed`=11, lo) with src1=3, src2=−5 → `result`=0xFFFF_FFFF_FFFF_FFF1. `out_valid` first high 65 cycles after acceptance.
- MULHU (`mul_signed`=00, hi) with src1=src2=0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFE.
- MULHSU with src1=−1, src2=2 → 0xFFFF_FFFF_FFFF_FFFF.
- DIVW src1=−7, src2=2 → 0xFFFF_FFFF_FFFF_FFFD at T+33. REMW with the same operands → 0xFFFF_FFFF_FFFF_FFFF.
- DIVU src1=5, src2=0 → all ones at T+1. REM src1=5, src2=0 → 5.
- DIV src1=0x8000_0000_0000_0000, src2=−1 → 0x8000_0000_0000_0000. REM → 0. Both at T+1.
- Flush 10 cycles into a DIV → `out_valid` never asserts; `in_ready`=1 the next cycle; a following MUL 6×7 returns 42.
- DONE with `out_ready` held low for 5 cycles → `result` and `out_valid` stable. Release → IDLE one cycle later.

Source files
------------

// File: rtl/mdu_seq.sv
// mdu_seq: iterative multiply/divide sequencer for the RV64 execute stage.
//
// It accepts one M-extension operation per handshake. It then runs a shared
// shift-add multiplier / restoring divider, one bit per cycle: 64 cycles for
// 64-bit ops and 32 cycles for W ops. The result is held until the consumer
// takes it. Divide-by-zero and signed overflow skip the iteration and go
// straight to the result.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   flush            kill any in-flight operation; blocks a same-cycle request
//   mul_valid        multiply request (wins if div_valid is also high)
//   div_valid        divide / remainder request
//   mul_signed[1:0]  [1] src1 signed, [0] src2 signed
//   mul_res_lo       1 = low XLEN product bits, 0 = high XLEN bits
//   div_signed[1:0]  2'b11 = signed divide, 2'b00 = unsigned
//   div_quotient     1 = quotient, 0 = remainder
//   inst_32          W variant: 32-bit operands, result sign-extended from bit 31
//   src1, src2       multiplicand/dividend, multiplier/divisor
//   in_ready         sequencer idle; a request is accepted this cycle
//   busy             iterating (MUL or DIV state)
//   out_valid        result is valid (DONE state)
//   out_ready        consumer takes the result
//   result           registered result
module mdu_seq #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            mul_valid,
  input  logic            div_valid,
  input  logic [1:0]      mul_signed,
  input  logic            mul_res_lo,
  input  logic [1:0]      div_signed,
  input  logic            div_quotient,
  input  logic            inst_32,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            in_ready,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST_D   = CW'(XLEN - 1);
  localparam logic [CW-1:0]   LAST_W   = CW'(31);
  localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};
  // Most negative value after the W extend step, for 64-bit and W ops.
  localparam logic [XLEN-1:0] MIN_D    = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W    = {{(XLEN-31){1'b1}}, {31{1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t state_reg, state_next;

  // Shared datapath.
  // For a multiply, acc_reg is {partial product, remaining multiplier bits}.
  // For a divide, it is {partial remainder, dividend bits / quotient bits}.
  // opb_reg holds the multiplicand or divisor magnitude.
  logic [2*XLEN-1:0] acc_reg;
  logic [XLEN-1:0]   opb_reg;
  logic [XLEN-1:0]   result_reg;
  logic [CW-1:0]     count_reg;
  logic              neg_reg;
  logic              w_reg;
  logic              lo_reg;
  logic              quo_reg;

  function automatic logic [XLEN-1:0] sext_w(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  // ------------------------------------------------------------------
  // Acceptance decode and operand preparation (from the request inputs)
  // ------------------------------------------------------------------
  logic            in_valid;
  logic            accept;
  logic            is_mul;
  logic            div_s;
  logic            sign_a;
  logic            sign_b;
  logic [XLEN-1:0] a_ext;
  logic [XLEN-1:0] b_ext;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic            div_zero;
  logic            div_ovf;
  logic            special;
  logic [XLEN-1:0] special_val;
  logic [XLEN-1:0] special_res;
  logic            neg_next;

  assign in_valid = mul_valid | div_valid;
  assign accept   = (state_reg == IDLE) & in_valid & ~flush;
  assign is_mul   = mul_valid;
  assign div_s    = &div_signed;
  assign sign_a   = is_mul ? mul_signed[1] : div_s;
  assign sign_b   = is_mul ? mul_signed[0] : div_s;

  // W ops only look at the low word; it is extended according to signedness.
  assign a_ext = inst_32 ? {{(XLEN-32){sign_a & src1[31]}}, src1[31:0]} : src1;
  assign b_ext = inst_32 ? {{(XLEN-32){sign_b & src2[31]}}, src2[31:0]} : src2;

  assign a_neg = sign_a & a_ext[XLEN-1];
  assign b_neg = sign_b & b_ext[XLEN-1];
  // -MIN wraps to MIN, which is the right unsigned magnitude (2^(XLEN-1)).
  assign a_mag = a_neg ? -a_ext : a_ext;
  assign b_mag = b_neg ? -b_ext : b_ext;

  // Remainder takes the dividend's sign; product and quotient take the XOR.
  assign neg_next = (is_mul | div_quotient) ? (a_neg ^ b_neg) : a_neg;

  assign div_zero = (b_ext == '0);
  assign div_ovf  = div_s & (b_ext == ALL_ONES) &
                    (a_ext == (inst_32 ? MIN_W : MIN_D));
  assign special  = ~is_mul & (div_zero | div_ovf);

  always_comb begin
    special_val = '0;
    if (div_zero) begin
      special_val = div_quotient ? ALL_ONES : a_ext;
    end else begin
      special_val = div_quotient ? a_ext : '0;
    end
  end

  assign special_res = inst_32 ? sext_w(special_val[31:0]) : special_val;

  // ------------------------------------------------------------------
  // One iteration step of each engine
  // ------------------------------------------------------------------
  logic [XLEN-1:0]   mul_addend;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step;
  logic [XLEN:0]     rem_sh;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] div_step;

  // Shift-add: add the multiplicand when the current multiplier LSB is 1,
  // then shift the 129-bit {carry, acc} right by one.
  assign mul_addend = acc_reg[0] ? opb_reg : '0;
  assign mul_sum    = {1'b0, acc_reg[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
  assign mul_step   = {mul_sum, acc_reg[XLEN-1:1]};

  // Restoring divide: shift the next dividend bit into the remainder, then
  // subtract the divisor when it fits. When it fits the true difference is
  // below 2^XLEN, so the modular low-word subtraction is exact.
  assign rem_sh   = acc_reg[2*XLEN-1:XLEN-1];
  assign div_ge   = (rem_sh >= {1'b0, opb_reg});
  assign div_diff = rem_sh[XLEN-1:0] - opb_reg;
  assign div_rem  = div_ge ? div_diff : rem_sh[XLEN-1:0];
  assign div_step = {div_rem, acc_reg[XLEN-2:0], div_ge};

  // ------------------------------------------------------------------
  // Result formatting on the final iteration
  // ------------------------------------------------------------------
  logic              last_iter;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   mul_val;
  logic [XLEN-1:0]   div_mag;
  logic [XLEN-1:0]   div_val;
  logic [XLEN-1:0]   fin_val;
  logic [XLEN-1:0]   fin_res;

  assign last_iter = (count_reg == (w_reg ? LAST_W : LAST_D));

  // After 32 steps the W product sits 32 bits above its final position.
  assign prod   = w_reg ? {{32{1'b0}}, mul_step[2*XLEN-1:32]} : mul_step;
  assign prod_s = neg_reg ? -prod : prod;

  always_comb begin
    mul_val = prod_s[XLEN-1:0];
    if (!lo_reg) begin
      mul_val = w_reg ? {{(XLEN-32){1'b0}}, prod_s[63:32]} : prod_s[2*XLEN-1:XLEN];
    end
  end

  // A W dividend starts left-aligned, so after 32 steps the quotient
  // occupies the low 32 bits and the remainder the high word.
  assign div_mag = quo_reg ? div_step[XLEN-1:0] : div_step[2*XLEN-1:XLEN];
  assign div_val = neg_reg ? -div_mag : div_mag;

  assign fin_val = (state_reg == MUL) ? mul_val : div_val;
  assign fin_res = w_reg ? sext_w(fin_val[31:0]) : fin_val;

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (is_mul) begin
            state_next = MUL;
          end else if (special) begin
            state_next = DONE;
          end else begin
            state_next = DIV;
          end
        end
      end
      MUL, DIV: begin
        if (flush) begin
          state_next = IDLE;
        end else if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (flush || out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Datapath registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg    <= '0;
      opb_reg    <= '0;
      result_reg <= '0;
      count_reg  <= '0;
      neg_reg    <= 1'b0;
      w_reg      <= 1'b0;
      lo_reg     <= 1'b0;
      quo_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            count_reg <= '0;
            neg_reg   <= neg_next;
            w_reg     <= inst_32;
            lo_reg    <= mul_res_lo;
            quo_reg   <= div_quotient;
            if (is_mul) begin
              acc_reg <= {{XLEN{1'b0}}, b_mag};
              opb_reg <= a_mag;
            end else begin
              acc_reg <= {{XLEN{1'b0}}, (inst_32 ? {a_mag[31:0], 32'b0} : a_mag)};
              opb_reg <= b_mag;
            end
            if (special) begin
              result_reg <= special_res;
            end
          end
        end
        MUL: begin
          if (!flush) begin
            acc_reg   <= mul_step;
            count_reg <= count_reg + CW'(1);
            if (last_iter) begin
              result_reg <= fin_res;
            end
          end
        end
        DIV: begin
          if (!flush) begin
            acc_reg   <= div_step;
            count_reg <= count_reg + CW'(1);
            if (last_iter) begin
              result_reg <= fin_res;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // All outputs come from registers or decode of the state register only.
  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg == MUL) || (state_reg == DIV);
  assign out_valid = (state_reg == DONE);
  assign result    = result_reg;

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed self-checking bench for mdu_seq.
// Each test task drives its own stimulus and compares against hand-computed
// expected values. Latency is counted in clock edges after the acceptance
// edge: 64-bit ops -> 64, W ops -> 32, special cases -> 0.
module tb_mdu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        mul_valid = 1'b0;
  logic        div_valid = 1'b0;
  logic [1:0]  mul_signed = 2'b00;
  logic        mul_res_lo = 1'b0;
  logic [1:0]  div_signed = 2'b00;
  logic        div_quotient = 1'b0;
  logic        inst_32 = 1'b0;
  logic [63:0] src1 = '0;
  logic [63:0] src2 = '0;
  logic        in_ready;
  logic        busy;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        is_mul;
    logic [1:0]  sgn;
    logic        sel;     // mul: 1 = lo; div: 1 = quotient
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    logic [7:0]  lat;
  } vec_t;

  mdu_seq #(.XLEN(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .mul_valid    (mul_valid),
    .div_valid    (div_valid),
    .mul_signed   (mul_signed),
    .mul_res_lo   (mul_res_lo),
    .div_signed   (div_signed),
    .div_quotient (div_quotient),
    .inst_32      (inst_32),
    .src1         (src1),
    .src2         (src2),
    .in_ready     (in_ready),
    .busy         (busy),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one request from IDLE, wait (bounded) for out_valid, optionally
  // complete the handshake. Returns the result, latency and busy right
  // after acceptance.
  task automatic run_op(input vec_t v, input bit take, output logic [63:0] res,
                        output int lat, output logic busy_first);
    mul_valid    = v.is_mul;
    div_valid    = !v.is_mul;
    mul_signed   = v.sgn;
    div_signed   = v.sgn;
    mul_res_lo   = v.sel;
    div_quotient = v.sel;
    inst_32      = v.w;
    src1         = v.a;
    src2         = v.b;
    @(posedge clk); #1;
    mul_valid  = 1'b0;
    div_valid  = 1'b0;
    busy_first = busy;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
    $display("op mul=%0b sgn=%b sel=%0b w=%0b a=%h b=%h -> result=%h lat=%0d",
             v.is_mul, v.sgn, v.sel, v.w, v.a, v.b, res, lat);
    if (take) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (result !== 64'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    vec_t v[6];
    logic [63:0] res;
    int lat;
    logic bf;
    v[0] = '{1'b1, 2'b11, 1'b1, 1'b0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 8'd64};
    v[1] = '{1'b1, 2'b00, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 8'd64};
    v[2] = '{1'b1, 2'b10, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 8'd64};
    v[3] = '{1'b1, 2'b11, 1'b1, 1'b1, 64'h1234_5678_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 8'd32};
    v[4] = '{1'b1, 2'b00, 1'b1, 1'b0, 64'h0000_0001_0000_0001, 64'h0000_0001_0000_0001, 64'h0000_0002_0000_0001, 8'd64};
    v[5] = '{1'b1, 2'b00, 1'b0, 1'b0, 64'h0000_0001_0000_0001, 64'h0000_0001_0000_0001, 64'h0000_0000_0000_0001, 8'd64};
    for (int i = 0; i < 6; i++) begin
      run_op(v[i], 1'b1, res, lat, bf);
      n_checks++; if (res !== v[i].exp) begin n_fail++; $display("FAIL mul[%0d]_result: got %h expected %h", i, res, v[i].exp); end
      n_checks++; if (lat != int'(v[i].lat)) begin n_fail++; $display("FAIL mul[%0d]_latency: got %0d expected %0d", i, lat, v[i].lat); end
      n_checks++; if (bf !== 1'b1) begin n_fail++; $display("FAIL mul[%0d]_busy: got %b expected 1", i, bf); end
    end
  endtask

  task automatic test_div();
    vec_t v[8];
    logic [63:0] res;
    int lat;
    logic bf;
    v[0] = '{1'b0, 2'b11, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 8'd32};
    v[1] = '{1'b0, 2'b11, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 8'd32};
    v[2] = '{1'b0, 2'b00, 1'b1, 1'b0, 64'd100, 64'd7, 64'd14, 8'd64};
    v[3] = '{1'b0, 2'b00, 1'b0, 1'b0, 64'd100, 64'd7, 64'd2, 8'd64};
    v[4] = '{1'b0, 2'b11, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 8'd64};
    v[5] = '{1'b0, 2'b11, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 8'd64};
    v[6] = '{1'b0, 2'b00, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h5555_5555_5555_5555, 8'd64};
    v[7] = '{1'b0, 2'b00, 1'b1, 1'b1, 64'hABCD_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 8'd32};
    for (int i = 0; i < 8; i++) begin
      run_op(v[i], 1'b1, res, lat, bf);
      n_checks++; if (res !== v[i].exp) begin n_fail++; $display("FAIL div[%0d]_result: got %h expected %h", i, res, v[i].exp); end
      n_checks++; if (lat != int'(v[i].lat)) begin n_fail++; $display("FAIL div[%0d]_latency: got %0d expected %0d", i, lat, v[i].lat); end
      n_checks++; if (bf !== 1'b1) begin n_fail++; $display("FAIL div[%0d]_busy: got %b expected 1", i, bf); end
    end
  endtask

  task automatic test_special();
    vec_t v[6];
    logic [63:0] res;
    int lat;
    logic bf;
    v[0] = '{1'b0, 2'b00, 1'b1, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 8'd0};
    v[1] = '{1'b0, 2'b11, 1'b0, 1'b0, 64'd5, 64'd0, 64'd5, 8'd0};
    v[2] = '{1'b0, 2'b11, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 8'd0};
    v[3] = '{1'b0, 2'b11, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 8'd0};
    v[4] = '{1'b0, 2'b11, 1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 8'd0};
    v[5] = '{1'b0, 2'b00, 1'b0, 1'b1, 64'h0000_0001_FFFF_FFF0, 64'h0000_0005_0000_0000, 64'hFFFF_FFFF_FFFF_FFF0, 8'd0};
    for (int i = 0; i < 6; i++) begin
      run_op(v[i], 1'b1, res, lat, bf);
      n_checks++; if (res !== v[i].exp) begin n_fail++; $display("FAIL special[%0d]_result: got %h expected %h", i, res, v[i].exp); end
      n_checks++; if (lat != 0) begin n_fail++; $display("FAIL special[%0d]_latency: got %0d expected 0", i, lat); end
      n_checks++; if (bf !== 1'b0) begin n_fail++; $display("FAIL special[%0d]_busy: got %b expected 0", i, bf); end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] res;
    int lat;
    logic bf;
    run_op('{1'b0, 2'b00, 1'b1, 1'b0, 64'd1000, 64'd9, 64'd111, 8'd64}, 1'b1, res, lat, bf);
    n_checks++; if (res !== 64'd111) begin n_fail++; $display("FAIL b2b_first: got %h expected %h", res, 64'd111); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready: got %b expected 1", in_ready); end
    run_op('{1'b0, 2'b00, 1'b0, 1'b0, 64'd1000, 64'd9, 64'd1, 8'd64}, 1'b1, res, lat, bf);
    n_checks++; if (res !== 64'd1) begin n_fail++; $display("FAIL b2b_second: got %h expected %h", res, 64'd1); end
    n_checks++; if (lat != 64) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 64", lat); end
  endtask

  task automatic test_flush();
    logic [63:0] res;
    int lat;
    logic bf;
    int seen;
    run_op('{1'b1, 2'b00, 1'b1, 1'b0, 64'd2, 64'd3, 64'd6, 8'd64}, 1'b1, res, lat, bf);
    n_checks++; if (res !== 64'd6) begin n_fail++; $display("FAIL flush_pre: got %h expected 6", res); end
    // Start a DIV and kill it 10 cycles in.
    div_valid = 1'b1; div_signed = 2'b00; div_quotient = 1'b1; inst_32 = 1'b0;
    src1 = 64'd100; src2 = 64'd7;
    @(posedge clk); #1;
    div_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    $display("flush: in_ready=%b busy=%b out_valid=%b", in_ready, busy, out_valid);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b expected 0", busy); end
    seen = 0;
    for (int c = 0; c < 80; c++) begin
      if (out_valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL flush_out_valid: got %0d valid cycles expected 0", seen); end
    n_checks++; if (result !== 64'd6) begin n_fail++; $display("FAIL flush_result_kept: got %h expected 6", result); end
    // A flush in the same cycle as a request blocks acceptance.
    mul_valid = 1'b1; mul_signed = 2'b00; mul_res_lo = 1'b1; src1 = 64'd4; src2 = 64'd4;
    flush = 1'b1;
    @(posedge clk); #1;
    mul_valid = 1'b0; flush = 1'b0;
    $display("flush+req: in_ready=%b busy=%b", in_ready, busy);
    n_checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL flush_blocks_accept: got in_ready=%b busy=%b expected 1 0", in_ready, busy); end
    run_op('{1'b1, 2'b11, 1'b1, 1'b0, 64'd6, 64'd7, 64'd42, 8'd64}, 1'b1, res, lat, bf);
    n_checks++; if (res !== 64'd42) begin n_fail++; $display("FAIL flush_post_mul: got %h expected 42", res); end
    n_checks++; if (lat != 64) begin n_fail++; $display("FAIL flush_post_latency: got %0d expected 64", lat); end
  endtask

  task automatic test_hold();
    logic [63:0] res;
    int lat;
    logic bf;
    run_op('{1'b1, 2'b11, 1'b1, 1'b0, 64'd9, 64'd9, 64'd81, 8'd64}, 1'b0, res, lat, bf);
    n_checks++; if (res !== 64'd81) begin n_fail++; $display("FAIL hold_result: got %h expected 81", res); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      $display("hold cycle %0d: out_valid=%b in_ready=%b result=%h", c, out_valid, in_ready, result);
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_out_valid[%0d]: got %b expected 1", c, out_valid); end
      n_checks++; if (result !== 64'd81) begin n_fail++; $display("FAIL hold_stable[%0d]: got %h expected 81", c, result); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready[%0d]: got %b expected 0", c, in_ready); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL release_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] res;
    int lat;
    logic bf;
    mul_valid = 1'b1; mul_signed = 2'b00; mul_res_lo = 1'b1; inst_32 = 1'b0;
    src1 = 64'd11; src2 = 64'd13;
    @(posedge clk); #1;
    mul_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    $display("mid reset: in_ready=%b busy=%b out_valid=%b result=%h", in_ready, busy, out_valid, result);
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (result !== 64'd0) begin n_fail++; $display("FAIL midreset_result: got %h expected 0", result); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op('{1'b1, 2'b00, 1'b1, 1'b0, 64'd11, 64'd13, 64'd143, 8'd64}, 1'b1, res, lat, bf);
    n_checks++; if (res !== 64'd143) begin n_fail++; $display("FAIL midreset_recover: got %h expected 143", res); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_back_to_back();
    test_flush();
    test_hold();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
